// File: rtl/debug_heartbeat_gen.sv
// debug_heartbeat_gen: multi-channel debug pin generator. Each channel drives
// a square wave (TOGGLE), a periodic one-cycle pulse (PULSE), or a stretched
// copy of a one-cycle event (STRETCH). Channels are configured by a single
// write strobe and run fully independently.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cfg_we     config write strobe (one cycle per write)
//   cfg_ch     channel index for the write (out-of-range writes are ignored)
//   cfg_mode   00 OFF, 01 TOGGLE, 10 PULSE, 11 STRETCH
//   cfg_period period value P
//   evt_in     per-channel event, active high, synchronous to clk
//   dbg_out    registered debug output per channel
//   wrap_pulse registered one-cycle strobe at each period end / stretch end
module debug_heartbeat_gen #(
  parameter int unsigned      NUM_CH       = 4,
  parameter int unsigned      CNT_W        = 16,
  parameter logic [1:0]       RESET_MODE   = 2'b01,
  parameter logic [CNT_W-1:0] RESET_PERIOD = '0,
  parameter int unsigned      IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [NUM_CH-1:0] evt_in,
  output logic [NUM_CH-1:0] dbg_out,
  output logic [NUM_CH-1:0] wrap_pulse
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_PULSE   = 2'b10,
    MODE_STRETCH = 2'b11
  } mode_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbg_q, dbg_d;
    logic             wrap_q, wrap_d;
    logic             sel;
    logic             hit;

    // Out-of-range indices never match any channel, so such writes are dropped.
    assign sel = cfg_we && (cfg_ch == IDX_W'(i));
    // Counter never exceeds P, so equality is the only end-of-period test.
    assign hit = (cnt_q == period_q);

    // Next-state for one channel: write > event > counting.
    always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      dbg_d    = dbg_q;
      wrap_d   = 1'b0;
      if (sel) begin
        mode_d   = mode_e'(cfg_mode);
        period_d = cfg_period;
        cnt_d    = '0;
        dbg_d    = 1'b0;
      end else begin
        unique case (mode_q)
          MODE_OFF: begin
            cnt_d = '0;
            dbg_d = 1'b0;
          end
          MODE_TOGGLE: begin
            if (hit) begin
              cnt_d  = '0;
              dbg_d  = ~dbg_q;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          MODE_PULSE: begin
            cnt_d  = hit ? '0 : cnt_q + CNT_W'(1);
            dbg_d  = hit;
            wrap_d = hit;
          end
          MODE_STRETCH: begin
            // A new event restarts the stretch window, even on its last cycle.
            if (evt_in[i]) begin
              dbg_d = 1'b1;
              cnt_d = '0;
            end else if (dbg_q) begin
              if (hit) begin
                dbg_d  = 1'b0;
                cnt_d  = '0;
                wrap_d = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              cnt_d = '0;
            end
          end
        endcase
      end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q   <= mode_e'(RESET_MODE);
        period_q <= RESET_PERIOD;
        cnt_q    <= '0;
        dbg_q    <= 1'b0;
        wrap_q   <= 1'b0;
      end else begin
        mode_q   <= mode_d;
        period_q <= period_d;
        cnt_q    <= cnt_d;
        dbg_q    <= dbg_d;
        wrap_q   <= wrap_d;
      end
    end

    assign dbg_out[i]    = dbg_q;
    assign wrap_pulse[i] = wrap_q;
  end

endmodule

// File: doc/debug_heartbeat_gen.md
# debug_heartbeat_gen

Multi-channel debug signal generator for board-level bring-up: each of NUM_CH channels drives a pin (LED, logic-analyser probe) with a programmable square wave, periodic pulse, or stretched copy of a one-cycle internal event. Replaces the single free-running bit-flip probe. With default parameters every channel leaves reset toggling on every clock, the same signature as the old probe. Sits at the top level next to the pin mux, configured by a simple write strobe from the control block.

## Interface
- NUM_CH, 4: number of independent channels (>=1)
- CNT_W, 16: width of period register and per-channel counter
- RESET_MODE, 2'b01: mode loaded into every channel at reset (TOGGLE)
- RESET_PERIOD, 0: period loaded into every channel at reset
- IDX_W, max(1, $clog2(NUM_CH)): derived, width of cfg_ch
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  config write strobe, one cycle per write
- cfg_ch  in  IDX_W  channel index for the write
- cfg_mode  in  2  00 OFF, 01 TOGGLE, 10 PULSE, 11 STRETCH
- cfg_period  in  CNT_W  period value P
- evt_in  in  NUM_CH  per-channel event, synchronous to clk, active high
- dbg_out  out  NUM_CH  registered debug output per channel
- wrap_pulse  out  NUM_CH  registered one-cycle strobe at each period end / stretch end

## Operation
- Per channel state: mode[1:0], period[CNT_W-1:0], cnt[CNT_W-1:0], dbg_out, wrap_pulse. Channels fully independent.
- Config write: on edge with cfg_we=1 and cfg_ch<NUM_CH, channel cfg_ch loads mode/period, cnt<=0, dbg_out<=0, wrap_pulse<=0. cfg_ch>=NUM_CH: write ignored, no state change anywhere.
- OFF: cnt<=0, dbg_out<=0, wrap_pulse<=0; evt_in ignored.
- TOGGLE: if cnt==P: cnt<=0, dbg_out<=~dbg_out, wrap_pulse<=1; else cnt<=cnt+1, wrap_pulse<=0. Full period 2(P+1) cycles.
- PULSE: same counting; dbg_out<=(cnt==P), wrap_pulse<=(cnt==P). High one cycle every P+1 cycles; P=0 gives constant high.
- STRETCH: evt_in=1: dbg_out<=1, cnt<=0, wrap_pulse<=0 (retrigger restarts). Else if dbg_out=1: at cnt==P dbg_out<=0, cnt<=0, wrap_pulse<=1; otherwise cnt<=cnt+1. Else idle, cnt held 0.
- Counter compare is equality on full CNT_W bits; cnt never exceeds P, no overflow path. P=all-ones legal.
- Priority per channel per edge: reset > config write > event > counting.

## Timing
- Reset (rst_n low, asynchronous): mode=RESET_MODE, period=RESET_PERIOD, cnt=0, dbg_out=0, wrap_pulse=0 on all channels, held while low. Release synchronous to next clk edge; first active edge after release is counting edge 1.
- TOGGLE, write at edge k: first dbg_out rise after edge k+P+1, then flips every P+1 edges; wrap_pulse high in the same cycles dbg_out changes.
- PULSE, write at edge k: first pulse after edge k+P+1, 1 cycle wide.
- STRETCH: evt_in sampled at edge e -> dbg_out high after e for exactly P+1 cycles if not retriggered; wrap_pulse high the cycle after dbg_out falls... precisely: wrap_pulse asserted in the same cycle dbg_out is first low (both set at edge e+P+1).
- Event coinciding with stretch end (cnt==P and evt_in=1): event wins, dbg_out stays 1, cnt<=0, no wrap_pulse.
- Config write coinciding with evt_in or wrap condition on the same channel: write wins, event lost.
- Writing the current mode/period again still restarts the channel (cnt, dbg_out cleared).
- Mid-operation reset aborts all counting immediately; no glitch beyond async clear.
- Outputs are flop outputs only; no combinational path from inputs to dbg_out/wrap_pulse.

## Test plan
- Reset with defaults, release, run 8 cycles -> all dbg_out toggle every cycle (0,1,0,1...), wrap_pulse constant 1 after first edge.
- Write ch1 TOGGLE P=3 -> dbg_out[1] 0 for 4 cycles, 1 for 4 cycles, repeating; wrap_pulse[1] every 4th cycle; other channels undisturbed.
- Write ch2 PULSE P=4 -> dbg_out[2] high 1 cycle in every 5; write P=0 -> constant high from second edge.
- Write ch3 STRETCH P=5; evt_in[3] one cycle -> high 6 cycles, then wrap_pulse[3] 1 cycle; retrigger at cnt=3 -> high 6 more cycles from retrigger; event at cnt=5 -> no wrap_pulse, stays high.
- Write cfg_ch=NUM_CH (out of range) with NUM_CH=3 -> no channel changes state; write OFF to ch0 -> dbg_out[0]=0 next cycle, evt ignored.
- Assert rst_n low mid-period on all modes, asynchronously between edges -> all outputs 0 immediately, reset mode/period restored after release.
